fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MIPS pipeline. Holds the PC, issues word requests to instruction memory over a req/ack handshake, and drives the IF/ID register. The decode stage consumes that register; its low half-word (id_imm16) feeds SignExtend directly. Supports decode stalls through a one-entry skid register and branch/jump redirects that flush in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held high with stable imem_addr until imem_ack
- imem_addr  out  32  word address of the outstanding request, bits [1:0] always 0
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle; may coincide with the first req cycle
- imem_rdata  in  32  instruction word
- stall  in  1  decode cannot accept a new instruction this cycle
- redirect  in  1  flush and fetch from redirect_pc (branch/jump resolved)
- redirect_pc  in  32  new target; bits [1:0] ignored (forced 0)
- id_valid  out  1  IF/ID register holds a live instruction
- id_instr  out  32  IF/ID instruction; 32'h0000_0000 (NOP) whenever id_valid=0
- id_pc_plus4  out  32  address of id_instr + 4
- id_imm16  out  16  id_instr[15:0], to SignExtend

## Operation
- States: FETCH (request outstanding), HOLD (instruction parked in skid, req low), DRAIN (redirect arrived before ack; waiting to discard).
- Reset: pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc_plus4=0, id_imm16=0, skid empty, imem_req=0 while reset is asserted; req rises on the first clock edge after release.
- FETCH, imem_addr=pc:
  - redirect=1: id_valid<=0. If imem_ack=1, drop the data, pc<=target, stay in FETCH. Otherwise latch the target and go to DRAIN.
  - imem_ack=1 and (stall=0 or id_valid=0): IF/ID<=rdata, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4, stay in FETCH.
  - imem_ack=1 and stall=1 and id_valid=1: skid<=rdata, pc<=pc+4, go to HOLD.
  - no ack and stall=0: id_valid<=0 (bubble).
- HOLD, imem_req=0:
  - redirect=1: discard skid, id_valid<=0, pc<=target, go to FETCH.
  - stall=0: IF/ID<=skid, go to FETCH.
- DRAIN: imem_req=1, imem_addr=old address. A new redirect overwrites the latched target (latest wins). On ack, discard the data, pc<=latched target, go to FETCH. id_valid stays 0.
- Priority: reset > redirect > stall.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- stall with id_valid=1 holds all id_* outputs unchanged.

## Timing
- ack in cycle N gives id_valid=1 in N+1.
- With same-cycle ack and no stall, throughput is one instruction per cycle.
- Redirect in cycle N gives imem_addr=target in N+1 if there is no outstanding un-acked request. Otherwise the target appears the cycle after the draining ack.
- The first instruction after a redirect reaches ID no earlier than N+2.
- No combinational path from stall/redirect to imem_addr; imem_req may depend combinationally only on state.
- Async reset mid-transaction abandons any outstanding request. The memory must tolerate req dropping without ack.

## Structure
- Shared package mips_pkg holds:
  - the fetch state enum (FETCH/HOLD/DRAIN)
  - MIPS_NOP=32'h0000_0000
  - the default reset vector constant
- Single module, no sub-modules. The skid register and FSM stay inline. SignExtend is instantiated by the decode stage, not here.

## Test plan
- Reset release, ack every cycle, rdata=addr: id_instr runs 0x0,0x4,0x8 on consecutive cycles; id_pc_plus4=0x4,0x8,0xC; id_imm16=id_instr[15:0].
- Ack 3 cycles late at addr 0x10: imem_addr is stable at 0x10 with req high for 3 cycles; then id_valid=1, id_instr=rdata, and one bubble per waiting cycle.
- stall=1 for 4 cycles while ack arrives: the word is parked in HOLD with req=0 and id_* unchanged. After stall drops, the parked word appears once and fetch resumes at the next address.
- redirect to 0x0000_0103 with ack delayed 2 cycles: DRAIN is entered, the late data is never presented, and the next imem_addr=0x100.
- RESET_PC=32'hFFFF_FFFC: the second fetch address is 0x0000_0000 and id_pc_plus4 of the first instruction is 0.
- reset asserted while in DRAIN and in HOLD: imem_req=0 and id_valid=0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS pipeline types and constants (fetch FSM, NOP, reset vector).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] MIPS_NOP          = 32'h0000_0000;
    localparam logic [31:0] MIPS_RESET_VECTOR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : MIPS instruction fetch: PC, imem req/ack, IF/ID register with skid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MIPS_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [15:0] id_imm16
);

    fetch_state_t r_state, w_state;
    logic         r_live,     w_live;
    logic [31:0]  r_pc,       w_pc;
    logic [31:0]  r_target,   w_target;
    logic [31:0]  r_skid,     w_skid;
    logic [31:0]  r_skid_pc4, w_skid_pc4;
    logic         r_valid,    w_valid;
    logic [31:0]  r_instr,    w_instr;
    logic [31:0]  r_pc4,      w_pc4;

    logic [31:0]  w_pc_inc;
    logic [31:0]  w_redir_tgt;
    logic [1:0]   w_unused_redir_lsb;

    assign w_pc_inc           = r_pc + 32'd4;
    assign w_redir_tgt        = {redirect_pc[31:2], 2'b00};
    assign w_unused_redir_lsb = redirect_pc[1:0];

    // r_live keeps req low until the first edge after reset release
    assign imem_req    = r_live && (r_state != HOLD);
    assign imem_addr   = r_pc;
    assign id_valid    = r_valid;
    assign id_instr    = r_instr;
    assign id_pc_plus4 = r_pc4;
    assign id_imm16    = r_instr[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_live     <= 1'b0;
            r_pc       <= RESET_PC;
            r_target   <= RESET_PC;
            r_skid     <= MIPS_NOP;
            r_skid_pc4 <= 32'd0;
            r_valid    <= 1'b0;
            r_instr    <= MIPS_NOP;
            r_pc4      <= 32'd0;
        end else begin
            r_state    <= w_state;
            r_live     <= w_live;
            r_pc       <= w_pc;
            r_target   <= w_target;
            r_skid     <= w_skid;
            r_skid_pc4 <= w_skid_pc4;
            r_valid    <= w_valid;
            r_instr    <= w_instr;
            r_pc4      <= w_pc4;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_live     = r_live;
        w_pc       = r_pc;
        w_target   = r_target;
        w_skid     = r_skid;
        w_skid_pc4 = r_skid_pc4;
        w_valid    = r_valid;
        w_instr    = r_instr;
        w_pc4      = r_pc4;

        case (r_state)
            FETCH: begin
                if (!r_live) begin
                    w_live = 1'b1;
                    if (redirect) begin
                        w_pc = w_redir_tgt;
                    end
                end else if (redirect) begin
                    w_valid = 1'b0;
                    w_instr = MIPS_NOP;
                    if (imem_ack) begin
                        w_pc = w_redir_tgt;
                    end else begin
                        w_target = w_redir_tgt;
                        w_state  = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!stall || !r_valid) begin
                        w_instr = imem_rdata;
                        w_pc4   = w_pc_inc;
                        w_valid = 1'b1;
                        w_pc    = w_pc_inc;
                    end else begin
                        // decode is full: park the word, drop req until it drains
                        w_skid     = imem_rdata;
                        w_skid_pc4 = w_pc_inc;
                        w_pc       = w_pc_inc;
                        w_state    = HOLD;
                    end
                end else if (!stall) begin
                    w_valid = 1'b0;
                    w_instr = MIPS_NOP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_valid = 1'b0;
                    w_instr = MIPS_NOP;
                    w_pc    = w_redir_tgt;
                    w_state = FETCH;
                end else if (!stall) begin
                    w_instr = r_skid;
                    w_pc4   = r_skid_pc4;
                    w_valid = 1'b1;
                    w_state = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    w_target = w_redir_tgt;
                end
                if (imem_ack) begin
                    w_pc    = redirect ? w_redir_tgt : r_target;
                    w_state = FETCH;
                end
            end
            default: begin
                w_state = FETCH;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Table-driven self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        r_reset;
    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_stall;
    logic        r_redir;
    logic [31:0] r_rpc;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic [15:0] w_imm;

    logic        r_reset2;
    logic        r_ack2;
    logic [31:0] r_rdata2;
    logic        w_req2;
    logic [31:0] w_addr2;
    logic        w_valid2;
    logic [31:0] w_instr2;
    logic [31:0] w_pc42;
    logic [15:0] w_imm2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(r_reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(r_ack), .imem_rdata(r_rdata),
        .stall(r_stall), .redirect(r_redir), .redirect_pc(r_rpc),
        .id_valid(w_valid), .id_instr(w_instr), .id_pc_plus4(w_pc4), .id_imm16(w_imm)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(r_reset2),
        .imem_req(w_req2), .imem_addr(w_addr2), .imem_ack(r_ack2), .imem_rdata(r_rdata2),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
        .id_valid(w_valid2), .id_instr(w_instr2), .id_pc_plus4(w_pc42), .id_imm16(w_imm2)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    vec_t vecs [35];

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic stall,
                                input logic redir, input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, input logic [31:0] pc4);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc4 = pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // ack / rdata / stall / redirect / redirect_pc | req / addr / valid / instr / pc+4
        vecs[0]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,         32'h0);
        vecs[1]  = mk(1'b1, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,         32'h0);
        vecs[2]  = mk(1'b1, 32'h4,         1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,         32'h4);
        vecs[3]  = mk(1'b1, 32'h8,         1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,         32'h8);
        vecs[4]  = mk(1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,         32'hC);
        vecs[5]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h1234_ABCD, 32'h10);
        vecs[6]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,         32'h0);
        vecs[7]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,         32'h0);
        vecs[8]  = mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,         32'h0);
        vecs[9]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'hDEAD_BEEF, 32'h14);
        vecs[10] = mk(1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'hDEAD_BEEF, 32'h14);
        vecs[11] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'hDEAD_BEEF, 32'h14);
        vecs[12] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'hDEAD_BEEF, 32'h14);
        vecs[13] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'hDEAD_BEEF, 32'h14);
        vecs[14] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'hDEAD_BEEF, 32'h14);
        vecs[15] = mk(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hCAFE_0001, 32'h18);
        vecs[16] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h103, 1'b1, 32'h1C,  1'b1, 32'h1111_2222, 32'h1C);
        vecs[17] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b0, 32'h0,         32'h0);
        vecs[18] = mk(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b0, 32'h0,         32'h0);
        vecs[19] = mk(1'b1, 32'h2000_0100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,         32'h0);
        vecs[20] = mk(1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h2000_0100, 32'h104);
        vecs[21] = mk(1'b1, 32'h4444_5555, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,         32'h0);
        vecs[22] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h4444_5555, 32'h204);
        vecs[23] = mk(1'b1, 32'h5,         1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0,         32'h0);
        vecs[24] = mk(1'b1, 32'h6,         1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h5,         32'h208);
        vecs[25] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h302, 1'b0, 32'h20C, 1'b1, 32'h5,         32'h208);
        vecs[26] = mk(1'b1, 32'h7,         1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,         32'h0);
        vecs[27] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h400, 1'b1, 32'h304, 1'b1, 32'h7,         32'h304);
        vecs[28] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h500, 1'b1, 32'h304, 1'b0, 32'h0,         32'h0);
        vecs[29] = mk(1'b1, 32'h99,        1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b0, 32'h0,         32'h0);
        vecs[30] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h500, 1'b0, 32'h0,         32'h0);
        vecs[31] = mk(1'b1, 32'h8,         1'b1, 1'b0, 32'h0,   1'b1, 32'h500, 1'b0, 32'h0,         32'h0);
        vecs[32] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h504, 1'b1, 32'h8,         32'h504);
        vecs[33] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h504, 1'b1, 32'h8,         32'h504);
        vecs[34] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h504, 1'b0, 32'h0,         32'h0);

        r_reset = 1'b1; r_ack = 1'b0; r_rdata = 32'h0; r_stall = 1'b0;
        r_redir = 1'b0; r_rpc = 32'h0;
        r_reset2 = 1'b1; r_ack2 = 1'b0; r_rdata2 = 32'h0;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",   {31'd0, w_req},   32'd0);
        chk("rst_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_instr", w_instr,          32'd0);
        chk("rst_pc4",   w_pc4,            32'd0);
        chk("rst_imm",   {16'd0, w_imm},   32'd0);
        chk("rst_addr",  w_addr,           32'd0);
        @(negedge clk);
        r_reset = 1'b0;

        for (int i = 0; i < 35; i++) begin
            r_ack   = vecs[i].ack;
            r_rdata = vecs[i].rdata;
            r_stall = vecs[i].stall;
            r_redir = vecs[i].redir;
            r_rpc   = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i),   {31'd0, w_req},   {31'd0, vecs[i].req});
            chk($sformatf("v%0d_addr", i),  w_addr,           vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, w_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_instr", i), w_instr,          vecs[i].instr);
            chk($sformatf("v%0d_imm", i),   {16'd0, w_imm},   {16'd0, vecs[i].instr[15:0]});
            if (vecs[i].valid)
                chk($sformatf("v%0d_pc4", i), w_pc4, vecs[i].pc4);
            @(negedge clk);
        end

        // async reset while draining
        r_ack = 1'b0; r_stall = 1'b0; r_redir = 1'b1; r_rpc = 32'h600;
        @(negedge clk);
        r_redir = 1'b0;
        #1;
        chk("drain_req",  {31'd0, w_req}, 32'd1);
        chk("drain_addr", w_addr,         32'h504);
        #2;
        r_reset = 1'b1;
        #1;
        chk("drain_rst_req",   {31'd0, w_req},   32'd0);
        chk("drain_rst_valid", {31'd0, w_valid}, 32'd0);
        chk("drain_rst_addr",  w_addr,           32'h0);
        @(negedge clk);
        r_reset = 1'b0;
        #1;
        chk("rel_req_low", {31'd0, w_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("rel_req_high", {31'd0, w_req}, 32'd1);
        chk("rel_addr",     w_addr,         32'h0);
        r_ack = 1'b1; r_rdata = 32'h77;
        @(negedge clk);
        r_ack = 1'b0;
        #1;
        chk("rel_valid", {31'd0, w_valid}, 32'd1);
        chk("rel_instr", w_instr,          32'h77);
        chk("rel_pc4",   w_pc4,            32'h4);
        chk("rel_addr2", w_addr,           32'h4);

        // async reset while holding a parked word
        r_ack = 1'b1; r_stall = 1'b1; r_rdata = 32'h88;
        @(negedge clk);
        r_ack = 1'b0;
        #1;
        chk("hold_req",   {31'd0, w_req},   32'd0);
        chk("hold_valid", {31'd0, w_valid}, 32'd1);
        chk("hold_instr", w_instr,          32'h77);
        #2;
        r_reset = 1'b1;
        #1;
        chk("hold_rst_req",   {31'd0, w_req},   32'd0);
        chk("hold_rst_valid", {31'd0, w_valid}, 32'd0);
        chk("hold_rst_instr", w_instr,          32'h0);
        chk("hold_rst_imm",   {16'd0, w_imm},   32'd0);
        @(negedge clk);
        r_reset = 1'b0; r_stall = 1'b0;
        @(negedge clk);
        #1;
        chk("hold_rel_req",  {31'd0, w_req}, 32'd1);
        chk("hold_rel_addr", w_addr,         32'h0);

        // PC wrap from the top of the address space
        @(negedge clk);
        r_reset2 = 1'b0;
        #1;
        chk("wrap_req0",  {31'd0, w_req2}, 32'd0);
        chk("wrap_addr0", w_addr2,         32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap_req1",  {31'd0, w_req2}, 32'd1);
        chk("wrap_addr1", w_addr2,         32'hFFFF_FFFC);
        r_ack2 = 1'b1; r_rdata2 = 32'h0000_1357;
        @(negedge clk);
        r_ack2 = 1'b0;
        #1;
        chk("wrap_addr2", w_addr2,          32'h0);
        chk("wrap_valid", {31'd0, w_valid2}, 32'd1);
        chk("wrap_instr", w_instr2,         32'h0000_1357);
        chk("wrap_pc4",   w_pc42,           32'h0);
        chk("wrap_imm",   {16'd0, w_imm2},  32'h1357);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
